// File: rtl/axi_slave_mem_128.sv
// AXI3 single-outstanding slave backed by a 2^DEPTH_LOG2 x 128-bit register array.
// One address/data/response transaction in flight; read/write arbitration alternates on contention.
module axi_slave_mem_128 #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic         i_aclk,
    input  logic         i_aresetn,
    // AW channel
    input  logic [3:0]   i_awid,
    input  logic [31:0]  i_awaddr,
    input  logic [3:0]   i_awlen,
    input  logic [2:0]   i_awsize,
    input  logic [1:0]   i_awburst,
    input  logic [1:0]   i_awlock,
    input  logic [3:0]   i_awcache,
    input  logic [2:0]   i_awprot,
    input  logic         i_awvalid,
    output logic         o_awready,
    // W channel
    input  logic [3:0]   i_wid,
    input  logic [127:0] i_wdata,
    input  logic [15:0]  i_wstrb,
    input  logic         i_wlast,
    input  logic         i_wvalid,
    output logic         o_wready,
    // B channel
    output logic [3:0]   o_bid,
    output logic [1:0]   o_bresp,
    output logic         o_bvalid,
    input  logic         i_bready,
    // AR channel
    input  logic [3:0]   i_arid,
    input  logic [31:0]  i_araddr,
    input  logic [3:0]   i_arlen,
    input  logic [2:0]   i_arsize,
    input  logic [1:0]   i_arburst,
    input  logic [1:0]   i_arlock,
    input  logic [3:0]   i_arcache,
    input  logic [2:0]   i_arprot,
    input  logic         i_arvalid,
    output logic         o_arready,
    // R channel
    output logic [3:0]   o_rid,
    output logic [127:0] o_rdata,
    output logic [1:0]   o_rresp,
    output logic         o_rlast,
    output logic         o_rvalid,
    input  logic         i_rready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WDATA,
        S_WRESP,
        S_RDATA
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [3:0]   r_id;
    logic [31:0]  r_addr;
    logic [3:0]   r_len;
    logic [1:0]   r_burst;
    logic [3:0]   r_beat_cnt;
    logic         r_burst_err;
    logic         r_wr_err;
    logic         r_wr_prio;
    logic [127:0] r_mem [DEPTH];

    logic                  w_addr_hs;
    logic [3:0]            w_sel_id;
    logic [31:0]           w_sel_addr;
    logic [3:0]            w_sel_len;
    logic [2:0]            w_sel_size;
    logic [1:0]            w_sel_burst;
    logic                  w_sel_err;
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_oor;
    logic                  w_beat_err;
    logic                  w_last;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_mem_we;
    logic [31:0]           w_wrap_mask;
    logic [31:0]           w_addr_inc;
    logic [31:0]           w_next_addr;

    // Protection, cache, lock and write-id carry no meaning for this memory.
    logic w_unused_fields;
    assign w_unused_fields = ^{i_awlock, i_awcache, i_awprot, i_arlock, i_arcache, i_arprot, i_wid};

    function automatic logic burst_error(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [3:0] len);
        logic w_bad_wrap_len;
        w_bad_wrap_len = !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
        return (size != 3'b100) || (burst == 2'b11) || (burst == BURST_WRAP && w_bad_wrap_len);
    endfunction

    // Ready is gated by reset so every output is low while reset is held.
    assign o_awready = i_aresetn && (r_state == S_IDLE) && i_awvalid && (!i_arvalid || r_wr_prio);
    assign o_arready = i_aresetn && (r_state == S_IDLE) && i_arvalid && (!i_awvalid || !r_wr_prio);
    assign w_addr_hs = o_awready || o_arready;

    assign w_sel_id    = o_awready ? i_awid    : i_arid;
    assign w_sel_addr  = o_awready ? i_awaddr  : i_araddr;
    assign w_sel_len   = o_awready ? i_awlen   : i_arlen;
    assign w_sel_size  = o_awready ? i_awsize  : i_arsize;
    assign w_sel_burst = o_awready ? i_awburst : i_arburst;
    assign w_sel_err   = burst_error(w_sel_size, w_sel_burst, w_sel_len);

    assign w_index    = r_addr[DEPTH_LOG2+3:4];
    assign w_oor      = |r_addr[31:DEPTH_LOG2+4];
    assign w_beat_err = r_burst_err || w_oor;
    assign w_last     = (r_beat_cnt == r_len);

    assign w_w_hs   = (r_state == S_WDATA) && i_wvalid;
    assign w_r_hs   = (r_state == S_RDATA) && i_rready;
    assign w_mem_we = w_w_hs && !w_beat_err;

    assign w_wrap_mask = (({28'd0, r_len} + 32'd1) << 4) - 32'd1;
    assign w_addr_inc  = r_addr + 32'd16;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_next_addr = w_addr_inc;
        if (r_burst == BURST_FIXED) begin
            w_next_addr = r_addr;
        end else if (r_burst == BURST_WRAP) begin
            w_next_addr = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (o_awready) begin
                    w_next_state = S_WDATA;
                end else if (o_arready) begin
                    w_next_state = S_RDATA;
                end
            end
            S_WDATA: if (i_wvalid && w_last) w_next_state = S_WRESP;
            S_WRESP: if (i_bready) w_next_state = S_IDLE;
            S_RDATA: if (i_rready && w_last) w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state     <= S_IDLE;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_burst     <= '0;
            r_beat_cnt  <= '0;
            r_burst_err <= 1'b0;
            r_wr_err    <= 1'b0;
            r_wr_prio   <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_addr_hs) begin
                r_id        <= w_sel_id;
                r_addr      <= w_sel_addr;
                r_len       <= w_sel_len;
                r_burst     <= w_sel_burst;
                r_beat_cnt  <= '0;
                r_burst_err <= w_sel_err;
                r_wr_err    <= w_sel_err;
                // The channel not granted now wins the next tie.
                r_wr_prio   <= o_arready;
            end else if (w_w_hs || w_r_hs) begin
                r_addr     <= w_next_addr;
                r_beat_cnt <= r_beat_cnt + 4'd1;
                if (w_w_hs && (w_oor || (w_last != i_wlast))) begin
                    r_wr_err <= 1'b1;
                end
            end
        end
    end

    // NOTE: the memory array is deliberately left without reset; it maps onto plain storage.
    always_ff @(posedge i_aclk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 16; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[w_index][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_wready = (r_state == S_WDATA);

    assign o_bvalid = (r_state == S_WRESP);
    assign o_bid    = o_bvalid ? r_id : 4'd0;
    assign o_bresp  = (o_bvalid && r_wr_err) ? RESP_SLVERR : RESP_OKAY;

    assign o_rvalid = (r_state == S_RDATA);
    assign o_rid    = o_rvalid ? r_id : 4'd0;
    assign o_rdata  = (o_rvalid && !w_beat_err) ? r_mem[w_index] : 128'd0;
    assign o_rresp  = (o_rvalid && w_beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign o_rlast  = o_rvalid && w_last;

endmodule

// File: tb/tb_axi_slave_mem_128.sv
// Directed bench for axi_slave_mem_128: bursts, wrap, strobes, errors, arbitration, reset abort.
module tb_axi_slave_mem_128;

    logic         i_aclk = 1'b0;
    logic         i_aresetn = 1'b0;
    logic [3:0]   i_awid = '0;
    logic [31:0]  i_awaddr = '0;
    logic [3:0]   i_awlen = '0;
    logic [2:0]   i_awsize = '0;
    logic [1:0]   i_awburst = '0;
    logic [1:0]   i_awlock = '0;
    logic [3:0]   i_awcache = '0;
    logic [2:0]   i_awprot = '0;
    logic         i_awvalid = 1'b0;
    logic         o_awready;
    logic [3:0]   i_wid = '0;
    logic [127:0] i_wdata = '0;
    logic [15:0]  i_wstrb = '0;
    logic         i_wlast = 1'b0;
    logic         i_wvalid = 1'b0;
    logic         o_wready;
    logic [3:0]   o_bid;
    logic [1:0]   o_bresp;
    logic         o_bvalid;
    logic         i_bready = 1'b0;
    logic [3:0]   i_arid = '0;
    logic [31:0]  i_araddr = '0;
    logic [3:0]   i_arlen = '0;
    logic [2:0]   i_arsize = '0;
    logic [1:0]   i_arburst = '0;
    logic [1:0]   i_arlock = '0;
    logic [3:0]   i_arcache = '0;
    logic [2:0]   i_arprot = '0;
    logic         i_arvalid = 1'b0;
    logic         o_arready;
    logic [3:0]   o_rid;
    logic [127:0] o_rdata;
    logic [1:0]   o_rresp;
    logic         o_rlast;
    logic         o_rvalid;
    logic         i_rready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [127:0] wd [16];
    logic [15:0]  ws [16];
    logic [127:0] rd_exp [16];
    logic [1:0]   rr_exp [16];

    axi_slave_mem_128 #(.DEPTH_LOG2(6)) dut (
        .i_aclk(i_aclk), .i_aresetn(i_aresetn),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
        .i_awburst(i_awburst), .i_awlock(i_awlock), .i_awcache(i_awcache), .i_awprot(i_awprot),
        .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wid(i_wid), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
        .i_wvalid(i_wvalid), .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arlock(i_arlock), .i_arcache(i_arcache), .i_arprot(i_arprot),
        .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready)
    );

    always #5 i_aclk = ~i_aclk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pat(input logic [31:0] base, input int i);
        return {4{base + 32'(i)}};
    endfunction

    task automatic fill_w(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wd[i] = pat(base, i);
            ws[i] = 16'hFFFF;
        end
    endtask

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
        i_awvalid = 1'b1;
        @(negedge i_aclk);
        while (!o_awready && n < 20) begin @(negedge i_aclk); n++; end
        check("aw_ready", o_awready, 1'b1);
        @(posedge i_aclk); #1;
        i_awvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
        int n = 0;
        i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = 3'd4; i_arburst = burst;
        i_arvalid = 1'b1;
        @(negedge i_aclk);
        while (!o_arready && n < 20) begin @(negedge i_aclk); n++; end
        check("ar_ready", o_arready, 1'b1);
        @(posedge i_aclk); #1;
        i_arvalid = 1'b0;
    endtask

    // early < 0: wlast on the final beat only; otherwise wlast only on beat 'early'.
    task automatic do_w(input logic [3:0] len, input int early);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            i_wdata = wd[i]; i_wstrb = ws[i];
            i_wlast = (early >= 0) ? (i == early) : (i == int'(len));
            i_wvalid = 1'b1;
            @(negedge i_aclk);
            while (!o_wready && n < 20) begin @(negedge i_aclk); n++; end
            check($sformatf("w_ready%0d", i), o_wready, 1'b1);
            @(posedge i_aclk); #1;
        end
        i_wvalid = 1'b0;
        i_wlast = 1'b0;
    endtask

    task automatic do_b(input logic [3:0] id, input logic [1:0] resp, input int stall);
        int n = 0;
        @(negedge i_aclk);
        while (!o_bvalid && n < 20) begin @(negedge i_aclk); n++; end
        check("b_valid", o_bvalid, 1'b1);
        check("b_id", o_bid, id);
        check("b_resp", o_bresp, resp);
        for (int s = 0; s < stall; s++) begin
            @(negedge i_aclk);
            check("b_stall", {o_bvalid, o_bid, o_bresp}, {1'b1, id, resp});
        end
        i_bready = 1'b1;
        @(posedge i_aclk); #1;
        i_bready = 1'b0;
        check("b_drop", o_bvalid, 1'b0);
    endtask

    task automatic do_r(input logic [3:0] id, input logic [3:0] len, input int stall_max);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            int stall;
            @(negedge i_aclk);
            while (!o_rvalid && n < 20) begin @(negedge i_aclk); n++; end
            check($sformatf("r_valid%0d", i), o_rvalid, 1'b1);
            check($sformatf("r_id%0d", i), o_rid, id);
            check($sformatf("r_data%0d", i), o_rdata, rd_exp[i]);
            check($sformatf("r_resp%0d", i), o_rresp, rr_exp[i]);
            check($sformatf("r_last%0d", i), o_rlast, (i == int'(len)));
            stall = int'($urandom_range(0, stall_max));
            for (int s = 0; s < stall; s++) begin
                @(negedge i_aclk);
                check($sformatf("r_stall%0d", i), {o_rvalid, o_rdata, o_rresp},
                      {1'b1, rd_exp[i], rr_exp[i]});
            end
            i_rready = 1'b1;
            @(posedge i_aclk); #1;
            i_rready = 1'b0;
        end
        check("r_drop", o_rvalid, 1'b0);
    endtask

    initial begin
        int nw;
        int nr;
        int n;

        // Reset: outputs low even with both address valids asserted.
        i_awvalid = 1'b1; i_arvalid = 1'b1;
        #12;
        check("rst_ready", {o_awready, o_arready, o_wready}, 3'b000);
        check("rst_valid", {o_bvalid, o_rvalid, o_rlast}, 3'b000);
        check("rst_data", o_rdata, 128'd0);
        i_awvalid = 1'b0; i_arvalid = 1'b0;
        @(negedge i_aclk);
        i_aresetn = 1'b1;
        @(posedge i_aclk); #1;

        // INCR write at 0x40 (indices 4..7) and at 0x00 (indices 0..3).
        fill_w(32'hD000_0000, 4);
        do_aw(4'h5, 32'h40, 4'd3, 3'd4, 2'b01);
        do_w(4'd3, -1);
        do_b(4'h5, 2'b00, 2);
        fill_w(32'hE000_0000, 4);
        do_aw(4'h1, 32'h00, 4'd3, 3'd4, 2'b01);
        do_w(4'd3, -1);
        do_b(4'h1, 2'b00, 0);

        // INCR read-back of D0..D3.
        for (int i = 0; i < 4; i++) begin rd_exp[i] = pat(32'hD000_0000, i); rr_exp[i] = 2'b00; end
        do_ar(4'h9, 32'h40, 4'd3, 2'b01);
        do_r(4'h9, 4'd3, 2);

        // WRAP len 3 from 0x30 visits indices 3,0,1,2.
        rd_exp[0] = pat(32'hE000_0000, 3);
        rd_exp[1] = pat(32'hE000_0000, 0);
        rd_exp[2] = pat(32'hE000_0000, 1);
        rd_exp[3] = pat(32'hE000_0000, 2);
        do_ar(4'h2, 32'h30, 4'd3, 2'b10);
        do_r(4'h2, 4'd3, 0);

        // WRAP with illegal len 2: three error beats with zero data.
        for (int i = 0; i < 3; i++) begin rd_exp[i] = 128'd0; rr_exp[i] = 2'b10; end
        do_ar(4'h3, 32'h00, 4'd2, 2'b10);
        do_r(4'h3, 4'd2, 0);

        // Partial strobe over an all-ones word.
        wd[0] = '1; ws[0] = 16'hFFFF;
        do_aw(4'h4, 32'h80, 4'd0, 3'd4, 2'b01);
        do_w(4'd0, -1);
        do_b(4'h4, 2'b00, 0);
        wd[0] = '0; ws[0] = 16'h0001;
        do_aw(4'h4, 32'h80, 4'd0, 3'd4, 2'b01);
        do_w(4'd0, -1);
        do_b(4'h4, 2'b00, 0);
        rd_exp[0] = {{120{1'b1}}, 8'h00}; rr_exp[0] = 2'b00;
        do_ar(4'h4, 32'h80, 4'd0, 2'b01);
        do_r(4'h4, 4'd0, 0);

        // Out-of-range write at 0x400 (would alias index 0) leaves memory untouched.
        wd[0] = {4{32'h1234_5678}}; ws[0] = 16'hFFFF;
        do_aw(4'h6, 32'h400, 4'd0, 3'd4, 2'b01);
        do_w(4'd0, -1);
        do_b(4'h6, 2'b10, 0);
        rd_exp[0] = pat(32'hE000_0000, 0); rr_exp[0] = 2'b00;
        do_ar(4'h6, 32'h00, 4'd0, 2'b01);
        do_r(4'h6, 4'd0, 0);

        // Bad size: error response and no write.
        wd[0] = {4{32'h0BAD_0BAD}};
        do_aw(4'h7, 32'h10, 4'd0, 3'd2, 2'b01);
        do_w(4'd0, -1);
        do_b(4'h7, 2'b10, 1);
        rd_exp[0] = pat(32'hE000_0000, 1);
        do_ar(4'h7, 32'h10, 4'd0, 2'b01);
        do_r(4'h7, 4'd0, 0);

        // Early wlast on beat 1 of len 3: error response, data still stored.
        fill_w(32'hF000_0000, 4);
        do_aw(4'h8, 32'h100, 4'd3, 3'd4, 2'b01);
        do_w(4'd3, 1);
        do_b(4'h8, 2'b10, 0);
        for (int i = 0; i < 4; i++) begin rd_exp[i] = pat(32'hF000_0000, i); rr_exp[i] = 2'b00; end
        do_ar(4'h8, 32'h100, 4'd3, 2'b01);
        do_r(4'h8, 4'd3, 1);

        // Contention: the previous grant was a read, so grants run W,R,W,R,W,R.
        nw = 0; nr = 0;
        i_awid = 4'hA; i_awaddr = 32'h200; i_awlen = 4'd0; i_awsize = 3'd4; i_awburst = 2'b01;
        i_arid = 4'hB; i_araddr = 32'h200; i_arlen = 4'd0; i_arsize = 3'd4; i_arburst = 2'b01;
        i_awvalid = 1'b1; i_arvalid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            n = 0;
            @(negedge i_aclk);
            while (!(o_awready || o_arready) && n < 20) begin @(negedge i_aclk); n++; end
            check($sformatf("arb_grant%0d", t), {o_awready, o_arready}, (t % 2 == 0) ? 2'b10 : 2'b01);
            if (o_awready) begin
                @(posedge i_aclk); #1;
                wd[0] = pat(32'hC0DE_0000, nw); ws[0] = 16'hFFFF;
                nw++;
                i_awaddr = 32'h200 + 32'(16 * nw);
                if (nw == 3) i_awvalid = 1'b0;
                do_w(4'd0, -1);
                do_b(4'hA, 2'b00, int'($urandom_range(0, 3)));
            end else if (o_arready) begin
                @(posedge i_aclk); #1;
                rd_exp[0] = pat(32'hC0DE_0000, nr); rr_exp[0] = 2'b00;
                nr++;
                i_araddr = 32'h200 + 32'(16 * nr);
                if (nr == 3) i_arvalid = 1'b0;
                do_r(4'hB, 4'd0, 3);
            end else begin
                break;
            end
        end
        i_awvalid = 1'b0; i_arvalid = 1'b0;

        // Reset during the second beat of a 4-beat read aborts it at once.
        rd_exp[0] = pat(32'hD000_0000, 0); rr_exp[0] = 2'b00;
        do_ar(4'hC, 32'h40, 4'd3, 2'b01);
        @(negedge i_aclk);
        check("mid_r0_data", o_rdata, rd_exp[0]);
        i_rready = 1'b1;
        @(posedge i_aclk); #1;
        i_rready = 1'b0;
        @(negedge i_aclk);
        check("mid_r1_valid", o_rvalid, 1'b1);
        #2 i_aresetn = 1'b0;
        #1;
        check("mid_rst_rvalid", o_rvalid, 1'b0);
        check("mid_rst_rdata", o_rdata, 128'd0);
        repeat (2) @(negedge i_aclk);
        i_aresetn = 1'b1;
        @(posedge i_aclk); #1;
        check("post_rst_idle", {o_rvalid, o_bvalid, o_wready}, 3'b000);
        wd[0] = pat(32'hAA00_0000, 0); ws[0] = 16'hFFFF;
        do_aw(4'hD, 32'h40, 4'd0, 3'd4, 2'b01);
        do_w(4'd0, -1);
        do_b(4'hD, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
